cdb_arbiter: RTL and testbench

//  Single-cycle round-robin arbiter for the common data bus shared by the lw, add, mul and mv result paths.

---
 rtl/cdb_arbiter.sv | 145 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared common data bus: one combinational grant per cycle,
// registered broadcast. Optional grant/conflict statistics under CDB_ARB_STATS_EN.
module cdb_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned UNIT_SIZE = 8,
  parameter int unsigned WORD_SIZE = 32,
  parameter logic [UNIT_SIZE-1:0] RSV_TAG = UNIT_SIZE'(8'h7F)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*UNIT_SIZE-1:0] req_tag,
  input  logic [NREQ*WORD_SIZE-1:0] req_data,
  output logic [NREQ-1:0]           req_gnt,
  output logic                      cdb_valid,
  output logic [UNIT_SIZE-1:0]      cdb_tag,
  output logic [WORD_SIZE-1:0]      cdb_data,
  output logic                      err_tag,
  output logic [31:0]               stat_grants,
  output logic [31:0]               stat_conflicts
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

  logic [UNIT_SIZE-1:0] tag_arr  [NREQ];
  logic [WORD_SIZE-1:0] data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign tag_arr[g]  = req_tag[g*UNIT_SIZE +: UNIT_SIZE];
    assign data_arr[g] = req_data[g*WORD_SIZE +: WORD_SIZE];
  end

  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_d;
  logic [PW-1:0]        win_idx;
  logic                 win_found;
  int unsigned          idx;
  logic [UNIT_SIZE-1:0] win_tag;
  logic [WORD_SIZE-1:0] win_data;

  logic                 cdb_valid_d;
  logic [UNIT_SIZE-1:0] cdb_tag_d;
  logic [WORD_SIZE-1:0] cdb_data_d;
  logic                 err_tag_d;

  // Search starts one past the last winner and wraps; first pending requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    idx       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!win_found && req_valid[PW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
    if (!rst_n || flush) begin
      win_found = 1'b0;
    end
  end

  always_comb begin
    req_gnt = '0;
    if (win_found) begin
      req_gnt[win_idx] = 1'b1;
    end
  end

  assign win_tag  = tag_arr[win_idx];
  assign win_data = data_arr[win_idx];

  // Next-state: a reserved-tag grant is consumed but flagged instead of broadcast.
  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag;
    cdb_data_d  = cdb_data;
    err_tag_d   = 1'b0;
    if (flush) begin
      ptr_d = PTR_RST;
    end else if (win_found) begin
      ptr_d = win_idx;
      if (win_tag == RSV_TAG) begin
        err_tag_d = 1'b1;
      end else begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = win_tag;
        cdb_data_d  = win_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PTR_RST;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      err_tag   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      cdb_valid <= cdb_valid_d;
      cdb_tag   <= cdb_tag_d;
      cdb_data  <= cdb_data_d;
      err_tag   <= err_tag_d;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic        multi_req;
  logic [31:0] stat_grants_d;
  logic [31:0] stat_conflicts_d;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi_req = |(req_valid & (req_valid - NREQ'(1)));

  always_comb begin
    stat_grants_d    = stat_grants;
    stat_conflicts_d = stat_conflicts;
    if (win_found) begin
      stat_grants_d = stat_grants + 32'd1;
    end
    if (multi_req && !flush) begin
      stat_conflicts_d = stat_conflicts + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_grants    <= stat_grants_d;
      stat_conflicts <= stat_conflicts_d;
    end
  end
`else
  assign stat_grants    = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts, a negedge monitor pops them.
module tb_cdb_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned US   = 8;
  localparam int unsigned WS   = 32;

  typedef struct packed {
    logic          err;
    logic [US-1:0] tag;
    logic [WS-1:0] data;
    int            stamp;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*US-1:0]   req_tag;
  logic [NREQ*WS-1:0]   req_data;
  logic [NREQ-1:0]      req_gnt;
  logic                 cdb_valid;
  logic [US-1:0]        cdb_tag;
  logic [WS-1:0]        cdb_data;
  logic                 err_tag;
  logic [31:0]          stat_grants;
  logic [31:0]          stat_conflicts;

  logic [US-1:0] tag_a  [NREQ];
  logic [WS-1:0] data_a [NREQ];
  exp_t          sb_q [$];
  int            cyc     = 0;
  int            n_checks = 0;
  int            n_fail   = 0;

  cdb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_tag        (req_tag),
    .req_data       (req_data),
    .req_gnt        (req_gnt),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .err_tag        (err_tag),
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_tag[i*US +: US]  = tag_a[i];
      req_data[i*WS +: WS] = data_a[i];
    end
  endtask

  // Called at a negedge: apply one cycle of stimulus, check the grant, queue the expected broadcast.
  task automatic step(input logic [3:0] v, input logic fl, input logic [3:0] eg, input string name);
    exp_t e;
    req_valid = v;
    flush     = fl;
    pack_inputs();
    #1;
    chk(name, 32'(req_gnt), 32'(eg));
    for (int i = 0; i < NREQ; i++) begin
      if (eg[i]) begin
        e.err   = (tag_a[i] == 8'h7F);
        e.tag   = tag_a[i];
        e.data  = data_a[i];
        e.stamp = cyc;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every broadcast or error pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (cdb_valid || err_tag) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {30'd0, err_tag, cdb_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("mon_valid", 32'(cdb_valid), 32'(!e.err));
        chk("mon_err", 32'(err_tag), 32'(e.err));
        if (!e.err) begin
          chk("mon_tag", 32'(cdb_tag), 32'(e.tag));
          chk("mon_data", cdb_data, e.data);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].stamp < cyc) begin
      e = sb_q.pop_front();
      chk("missing_output", 32'd0, 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      tag_a[i]  = US'(8'h10 + i);
      data_a[i] = 32'hA000_0000 + WS'(i * 32'h111);
    end
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b1111;
    pack_inputs();

    // Reset holds everything quiet even with all requests pending.
    #3;
    chk("rst_gnt", 32'(req_gnt), 32'd0);
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    chk("rst_tag", 32'(cdb_tag), 32'd0);
    chk("rst_data", cdb_data, 32'd0);
    @(negedge clk);
    chk("rst_gnt_hold", 32'(req_gnt), 32'd0);
    chk("rst_err", 32'(err_tag), 32'd0);
    chk("rst_stat_g", stat_grants, 32'd0);
    rst_n = 1'b1;

    // All four held for eight cycles: rotation 0,1,2,3,0,1,2,3.
    step(4'b1111, 1'b0, 4'b0001, "rr_g0");
    step(4'b1111, 1'b0, 4'b0010, "rr_g1");
    step(4'b1111, 1'b0, 4'b0100, "rr_g2");
    step(4'b1111, 1'b0, 4'b1000, "rr_g3");
    step(4'b1111, 1'b0, 4'b0001, "rr_g4");
    step(4'b1111, 1'b0, 4'b0010, "rr_g5");
    step(4'b1111, 1'b0, 4'b0100, "rr_g6");
    step(4'b1111, 1'b0, 4'b1000, "rr_g7");
`ifdef CDB_ARB_STATS_EN
    chk("stat_grants_8", stat_grants, 32'd8);
    chk("stat_conf_8", stat_conflicts, 32'd8);
`else
    chk("stat_grants_off", stat_grants, 32'd0);
    chk("stat_conf_off", stat_conflicts, 32'd0);
`endif

    // Single request, then idle so the broadcast must drop.
    tag_a[1]  = 8'h21;
    data_a[1] = 32'd7;
    step(4'b0010, 1'b0, 4'b0010, "single_req1");
    step(4'b0000, 1'b0, 4'b0000, "single_idle");

    // ptr=2 with requesters 0 and 1 pending: wrap through 3 to 0, then 1.
    step(4'b0100, 1'b0, 4'b0100, "set_ptr2");
    step(4'b0011, 1'b0, 4'b0001, "wrap_req0");
    step(4'b0010, 1'b0, 4'b0010, "then_req1");

    // Reserved tag: granted, no broadcast, one-cycle error pulse.
    tag_a[3] = 8'h7F;
    step(4'b1000, 1'b0, 4'b1000, "rsv_gnt");
    step(4'b0000, 1'b0, 4'b0000, "rsv_idle0");
    chk("rsv_err_gone", 32'(err_tag), 32'd0);
    step(4'b0000, 1'b0, 4'b0000, "rsv_idle1");

    // Flush with 1 and 2 pending after ptr=1: no grant, then ptr reset makes 1 win.
    step(4'b0010, 1'b0, 4'b0010, "set_ptr1");
    step(4'b0110, 1'b1, 4'b0000, "flush_gnt");
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    step(4'b0110, 1'b0, 4'b0010, "post_flush");
    step(4'b0000, 1'b0, 4'b0000, "final_idle");
    step(4'b0000, 1'b0, 4'b0000, "drain_idle");

`ifdef CDB_ARB_STATS_EN
    chk("stat_grants_end", stat_grants, 32'd15);
    chk("stat_conf_end", stat_conflicts, 32'd10);
`else
    chk("stat_grants_end", stat_grants, 32'd0);
    chk("stat_conf_end", stat_conflicts, 32'd0);
`endif
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset mid-broadcast: the in-flight result vanishes immediately.
    req_valid = 4'b0001;
    #1;
    chk("mid_gnt", 32'(req_gnt), 32'd1);
    @(posedge clk);
    #2;
    chk("mid_valid_before", 32'(cdb_valid), 32'd1);
    chk("mid_tag_before", 32'(cdb_tag), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("mid_valid_rst", 32'(cdb_valid), 32'd0);
    chk("mid_tag_rst", 32'(cdb_tag), 32'd0);
    chk("mid_data_rst", cdb_data, 32'd0);
    chk("mid_gnt_rst", 32'(req_gnt), 32'd0);
    chk("mid_stat_rst", stat_grants, 32'd0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("end_valid", 32'(cdb_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
